// File: rtl/sort_sched_pkg.sv
// sort_sched_pkg: shared FSM state type for the sort job scheduler
package sort_sched_pkg;
  typedef enum logic [1:0] {CLEAR, IDLE, LOAD, DRAIN} state_e;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot cyclic pick of the first request at or above ptr_i
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o
);
  logic [PW-1:0] w_idx;
  always_comb begin
    gnt_o = '0;
    w_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      w_idx = PW'((int'(ptr_i) + i) % N);
      if (req_i[w_idx]) begin
        gnt_o = '0;
        gnt_o[w_idx] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/sort_job_scheduler.sv
// sort_job_scheduler: round-robin time-sharing of one counting-sort engine with a stall watchdog
module sort_job_scheduler
  import sort_sched_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 5,
  parameter int DATA_SIZE  = 4,
  parameter int TIMEOUT    = 256,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NUM_REQ-1:0]              req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data_i,
  output logic [NUM_REQ-1:0]              req_ready_o,
  output logic [NUM_REQ-1:0]              resp_valid_o,
  output logic [DATA_WIDTH-1:0]           resp_data_o,
  input  logic [NUM_REQ-1:0]              resp_ready_i,
  output logic                            eng_write_valid_o,
  input  logic                            eng_write_ready_i,
  output logic [DATA_WIDTH-1:0]           eng_write_data_o,
  input  logic                            eng_read_valid_i,
  output logic                            eng_read_ready_o,
  input  logic [DATA_WIDTH-1:0]           eng_read_data_i,
  output logic                            eng_clear_o,
  output logic [NUM_REQ-1:0]              grant_o,
  output logic                            busy_o,
  output logic                            abort_o,
  output logic [CNT_WIDTH-1:0]            job_count_o
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int BW = $clog2(DATA_SIZE) + 1;
  localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  state_e                r_state, w_state_nx;
  logic [NUM_REQ-1:0]    r_grant, w_grant_nx, w_win;
  logic [PW-1:0]         r_rr_ptr, w_rr_ptr_nx, w_gidx, w_ptr_after;
  logic [BW-1:0]         r_beat, w_beat_nx;
  logic [WW-1:0]         r_wdog, w_wdog_nx;
  logic [CNT_WIDTH-1:0]  r_jobs, w_jobs_nx;
  logic                  w_req_v, w_resp_r, w_wr_hs, w_rd_hs, w_hs, w_last, w_timeout;
  logic [DATA_WIDTH-1:0] w_req_d;

  rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_arb (
    .req_i (req_valid_i),
    .ptr_i (r_rr_ptr),
    .gnt_o (w_win)
  );

  always_comb begin
    w_gidx   = '0;
    w_req_v  = 1'b0;
    w_req_d  = '0;
    w_resp_r = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (r_grant[k]) begin
        w_gidx   = PW'(k);
        w_req_v  = req_valid_i[k];
        w_req_d  = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
        w_resp_r = resp_ready_i[k];
      end
    end
  end

  assign eng_write_valid_o = (r_state == LOAD) && w_req_v;
  assign eng_write_data_o  = (r_state == LOAD) ? w_req_d : '0;
  assign req_ready_o       = ((r_state == LOAD) && eng_write_ready_i) ? r_grant : '0;
  assign resp_valid_o      = ((r_state == DRAIN) && eng_read_valid_i) ? r_grant : '0;
  assign eng_read_ready_o  = (r_state == DRAIN) && w_resp_r;
  assign resp_data_o       = (r_state == DRAIN) ? eng_read_data_i : '0;
  assign eng_clear_o       = (r_state == CLEAR);
  assign grant_o           = r_grant;
  assign busy_o            = (r_state == LOAD) || (r_state == DRAIN);
  assign job_count_o       = r_jobs;
  assign abort_o           = w_timeout;

  assign w_wr_hs     = eng_write_valid_o && eng_write_ready_i;
  assign w_rd_hs     = eng_read_ready_o && eng_read_valid_i;
  assign w_hs        = w_wr_hs || w_rd_hs;
  assign w_last      = (r_beat == BW'(DATA_SIZE - 1));
  assign w_ptr_after = (w_gidx == PW'(NUM_REQ - 1)) ? '0 : w_gidx + PW'(1);
  // A handshake in the final watchdog cycle keeps the job alive
  assign w_timeout   = (TIMEOUT != 0) && busy_o && !w_hs && (r_wdog == WW'(TIMEOUT - 1));

  always_comb begin
    w_state_nx  = r_state;
    w_grant_nx  = r_grant;
    w_rr_ptr_nx = r_rr_ptr;
    w_beat_nx   = r_beat;
    w_wdog_nx   = busy_o ? (w_hs ? '0 : r_wdog + WW'(1)) : r_wdog;
    w_jobs_nx   = r_jobs;
    unique case (r_state)
      CLEAR: w_state_nx = IDLE;
      IDLE: begin
        if (|req_valid_i) begin
          w_grant_nx = w_win;
          w_beat_nx  = '0;
          w_wdog_nx  = '0;
          w_state_nx = LOAD;
        end
      end
      LOAD: begin
        if (w_wr_hs) begin
          w_beat_nx  = w_last ? '0 : r_beat + BW'(1);
          w_state_nx = w_last ? DRAIN : LOAD;
        end
      end
      DRAIN: begin
        if (w_rd_hs) begin
          w_beat_nx = w_last ? '0 : r_beat + BW'(1);
          if (w_last) begin
            w_jobs_nx   = r_jobs + CNT_WIDTH'(1);
            w_rr_ptr_nx = w_ptr_after;
            w_grant_nx  = '0;
            w_state_nx  = CLEAR;
          end
        end
      end
    endcase
    if (w_timeout) begin
      w_rr_ptr_nx = w_ptr_after;
      w_grant_nx  = '0;
      w_beat_nx   = '0;
      w_state_nx  = CLEAR;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= CLEAR;
      r_grant  <= '0;
      r_rr_ptr <= '0;
      r_beat   <= '0;
      r_wdog   <= '0;
      r_jobs   <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_grant  <= w_grant_nx;
      r_rr_ptr <= w_rr_ptr_nx;
      r_beat   <= w_beat_nx;
      r_wdog   <= w_wdog_nx;
      r_jobs   <= w_jobs_nx;
    end
  end
endmodule

// File: tb/tb_sort_job_scheduler.sv
// tb_sort_job_scheduler: directed checks of arbitration, job flow, watchdog abort and async reset
module tb_sort_job_scheduler;
  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [3:0]  req_valid_i = '0;
  logic [19:0] req_data_i = '0;
  logic [3:0]  resp_ready_i = '0;
  logic        eng_write_ready_i = 1'b0;
  logic        eng_read_valid_i = 1'b0;
  logic [4:0]  eng_read_data_i = '0;
  logic [3:0]  req_ready_o, resp_valid_o, grant_o;
  logic [4:0]  resp_data_o, eng_write_data_o;
  logic        eng_write_valid_o, eng_read_ready_o, eng_clear_o, busy_o, abort_o;
  logic [15:0] job_count_o;
  logic [3:0]  req_ready8, resp_valid8, grant8;
  logic [4:0]  resp_data8, eng_write_data8;
  logic        eng_write_valid8, eng_read_ready8, eng_clear8, busy8, abort8;
  logic [15:0] job_count8;
  int n_cmp = 0;
  int n_err = 0;
  int exp_jobs = 0;

  always #5 clk_i = ~clk_i;

  sort_job_scheduler u_dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_ready_o(req_ready_o),
    .resp_valid_o(resp_valid_o), .resp_data_o(resp_data_o), .resp_ready_i(resp_ready_i),
    .eng_write_valid_o(eng_write_valid_o), .eng_write_ready_i(eng_write_ready_i),
    .eng_write_data_o(eng_write_data_o), .eng_read_valid_i(eng_read_valid_i),
    .eng_read_ready_o(eng_read_ready_o), .eng_read_data_i(eng_read_data_i),
    .eng_clear_o(eng_clear_o), .grant_o(grant_o), .busy_o(busy_o),
    .abort_o(abort_o), .job_count_o(job_count_o)
  );

  sort_job_scheduler #(.TIMEOUT(8)) u_dut8 (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_ready_o(req_ready8),
    .resp_valid_o(resp_valid8), .resp_data_o(resp_data8), .resp_ready_i(resp_ready_i),
    .eng_write_valid_o(eng_write_valid8), .eng_write_ready_i(eng_write_ready_i),
    .eng_write_data_o(eng_write_data8), .eng_read_valid_i(eng_read_valid_i),
    .eng_read_ready_o(eng_read_ready8), .eng_read_data_i(eng_read_data_i),
    .eng_clear_o(eng_clear8), .grant_o(grant8), .busy_o(busy8),
    .abort_o(abort8), .job_count_o(job_count8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    req_valid_i = '0;
    req_data_i = '0;
    resp_ready_i = '0;
    eng_write_ready_i = 1'b0;
    eng_read_valid_i = 1'b0;
    eng_read_data_i = '0;
    exp_jobs = 0;
    #1;
    chk("rst_clear", eng_clear_o, 1);
    chk("rst_grant", grant_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_jobs", job_count_o, 0);
    chk("rst_clear8", eng_clear8, 1);
    tick();
    tick();
    rst_ni = 1'b1;
    #1;
    chk("post_rst_clear", eng_clear_o, 1);
    tick();
  endtask

  task automatic beat_in(input int r, input logic [4:0] d);
    req_valid_i[r] = 1'b1;
    req_data_i[r*5 +: 5] = d;
    eng_write_ready_i = 1'b1;
    #1;
    chk("wr_valid", eng_write_valid_o, 1);
    chk("wr_data", eng_write_data_o, d);
    chk("req_ready", req_ready_o, 1 << r);
    tick();
  endtask

  task automatic beat_out(input int r, input logic [4:0] d);
    eng_read_valid_i = 1'b1;
    eng_read_data_i = d;
    resp_ready_i = 4'(1 << r);
    #1;
    chk("resp_valid", resp_valid_o, 1 << r);
    chk("resp_data", resp_data_o, d);
    chk("rd_ready", eng_read_ready_o, 1);
    chk("drain_no_wr", req_ready_o, 0);
    tick();
  endtask

  task automatic job(input int r, input logic [4:0] off);
    #1;
    chk("idle_clear", eng_clear_o, 0);
    chk("idle_grant", grant_o, 0);
    chk("idle_ready", req_ready_o, 0);
    tick();
    #1;
    chk("grant", grant_o, 1 << r);
    chk("busy", busy_o, 1);
    beat_in(r, off + 5'd3);
    beat_in(r, off + 5'd1);
    beat_in(r, off + 5'd2);
    beat_in(r, off);
    req_valid_i[r] = 1'b0;
    eng_write_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) beat_out(r, off + 5'(i));
    eng_read_valid_i = 1'b0;
    resp_ready_i = '0;
    exp_jobs++;
    #1;
    chk("clear_between", eng_clear_o, 1);
    chk("grant_free", grant_o, 0);
    chk("job_count", job_count_o, exp_jobs);
    tick();
  endtask

  initial begin
    // 1: reset and idle
    do_reset();
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("idle_clear", eng_clear_o, 0);
      chk("idle_grant", grant_o, 0);
      chk("idle_jobs", job_count_o, 0);
      tick();
    end
    // 2: single requester 1
    req_valid_i = 4'b0010;
    job(1, 5'd0);
    // 3: requesters 0,2,3 together, then fresh 0
    do_reset();
    req_valid_i = 4'b1101;
    job(0, 5'd4);
    job(2, 5'd8);
    job(3, 5'd12);
    req_valid_i[0] = 1'b1;
    job(0, 5'd16);
    // 4: granted requester 2 pauses while requester 0 waits
    req_valid_i = 4'b0101;
    #1;
    chk("t4_idle", grant_o, 0);
    tick();
    #1;
    chk("t4_grant", grant_o, 4'b0100);
    beat_in(2, 5'd7);
    beat_in(2, 5'd5);
    req_valid_i[2] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("t4_hold_grant", grant_o, 4'b0100);
      chk("t4_ready", req_ready_o, 4'b0100);
      chk("t4_no_wr", eng_write_valid_o, 0);
      tick();
    end
    beat_in(2, 5'd6);
    beat_in(2, 5'd4);
    req_valid_i = '0;
    eng_write_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) beat_out(2, 5'd4 + 5'(i));
    eng_read_valid_i = 1'b0;
    resp_ready_i = '0;
    exp_jobs++;
    #1;
    chk("t4_clear", eng_clear_o, 1);
    chk("t4_jobs", job_count_o, exp_jobs);
    tick();
    // 5: watchdog abort with TIMEOUT=8
    do_reset();
    req_valid_i = 4'b0010;
    #1;
    chk("t5_idle8", grant8, 0);
    tick();
    #1;
    chk("t5_grant8", grant8, 4'b0010);
    for (int i = 0; i < 4; i++) beat_in(1, 5'(i));
    req_valid_i = '0;
    eng_write_ready_i = 1'b0;
    eng_read_valid_i = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      #1;
      chk("t5_abort8", abort8, (i == 8) ? 1 : 0);
      chk("t5_busy8", busy8, 1);
      if (i == 8) chk("t5_abort256", abort_o, 0);
      tick();
    end
    eng_read_valid_i = 1'b0;
    #1;
    chk("t5_clear8", eng_clear8, 1);
    chk("t5_pulse8", abort8, 0);
    chk("t5_grant_free8", grant8, 0);
    chk("t5_jobs8", job_count8, 0);
    chk("t5_still_busy", busy_o, 1);
    tick();
    req_valid_i = 4'b0110;
    #1;
    chk("t5_idle_again8", grant8, 0);
    tick();
    #1;
    chk("t5_next_grant8", grant8, 4'b0100);
    // 6: asynchronous reset mid-LOAD
    do_reset();
    req_valid_i = 4'b0001;
    #1;
    chk("t6_idle", grant_o, 0);
    tick();
    beat_in(0, 5'd9);
    beat_in(0, 5'd3);
    rst_ni = 1'b0;
    #1;
    chk("t6_clear", eng_clear_o, 1);
    chk("t6_grant", grant_o, 0);
    chk("t6_busy", busy_o, 0);
    chk("t6_wr_valid", eng_write_valid_o, 0);
    chk("t6_ready", req_ready_o, 0);
    chk("t6_wr_data", eng_write_data_o, 0);
    chk("t6_jobs", job_count_o, 0);
    req_valid_i = '0;
    eng_write_ready_i = 1'b0;
    tick();
    rst_ni = 1'b1;
    #1;
    chk("t6_post_clear", eng_clear_o, 1);
    tick();
    req_valid_i = 4'b1000;
    job(3, 5'd20);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
